rr_grant_arbiter: RTL and testbench

Four-way round-robin arbiter that shares one downstream resource among four requesters. It produces a registered one-hot grant, the matching 2-bit encoded index (00..11 for requesters 0..3), and a grant-valid flag. It sits in front of the shared datapath: `gnt_idx` drives the datapath select and `gnt_valid` qualifies it. A hold-time limit stops any one requester from holding the resource indefinitely.

---
 rtl/rr_grant_arbiter.sv | 111 +++++++++++
 tb/tb_rr_grant_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - four-way round-robin arbiter with hold-time limit
module rr_grant_arbiter #(
   parameter int HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       expired
);

   typedef enum logic {IDLE, GRANT} state_e;

   // Last hold_cnt value before the owner is forced off (HOLD_MAX=256 -> 255).
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   state_e      state_q, state_d;
   logic [1:0]  last_q, last_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;
   logic [3:0]  gnt_q, gnt_d;
   logic [1:0]  gnt_idx_q, gnt_idx_d;
   logic        expired_q, expired_d;

   logic        win_found;
   logic [1:0]  win_idx;

   // Returns {found, index}: first set request starting just after 'last',
   // so 'last' itself is examined at the very end (lowest priority).
   function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] cand;
      res = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         cand = last + 2'(i);
         if (r[cand]) res = {1'b1, cand};
      end
      return res;
   endfunction

   // In GRANT, last_q is the current owner, so one search serves both states.
   always_comb begin
      {win_found, win_idx} = rr_pick(req, last_q);
   end

   // Next-state logic: arbitration on idle, release and hold-limit handling on grant.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = gnt_q;
      gnt_idx_d  = gnt_idx_q;
      expired_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d    = GRANT;
               gnt_d      = 4'b0001 << win_idx;
               gnt_idx_d  = win_idx;
               last_d     = win_idx;
               hold_cnt_d = 8'd0;
            end
         end
         GRANT: begin
            if (!req[last_q] || hold_cnt_q == HOLD_LAST) begin
               // Voluntary release wins over the limit, so expiry needs req still high.
               expired_d  = req[last_q];
               hold_cnt_d = 8'd0;
               if (win_found) begin
                  gnt_d     = 4'b0001 << win_idx;
                  gnt_idx_d = win_idx;
                  last_d    = win_idx;
               end else begin
                  state_d   = IDLE;
                  gnt_d     = 4'b0000;
                  gnt_idx_d = 2'd0;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset clears outputs without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         last_q     <= 2'd3;
         hold_cnt_q <= 8'd0;
         gnt_q      <= 4'b0000;
         gnt_idx_q  <= 2'd0;
         expired_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
         gnt_idx_q  <= gnt_idx_d;
         expired_q  <= expired_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = (state_q == GRANT);
   assign expired   = expired_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - scoreboard bench for rr_grant_arbiter at HOLD_MAX 8, 4 and 1
module tb_rr_grant_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req = 4'b0000;

   logic [3:0] gnt_8, gnt_4, gnt_1;
   logic [1:0] idx_8, idx_4, idx_1;
   logic       vld_8, vld_4, vld_1;
   logic       exp_8, exp_4, exp_1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rr_grant_arbiter #(.HOLD_MAX(8)) u_dut8 (
      .clk(clk), .rst(rst), .req(req),
      .gnt(gnt_8), .gnt_idx(idx_8), .gnt_valid(vld_8), .expired(exp_8));
   rr_grant_arbiter #(.HOLD_MAX(4)) u_dut4 (
      .clk(clk), .rst(rst), .req(req),
      .gnt(gnt_4), .gnt_idx(idx_4), .gnt_valid(vld_4), .expired(exp_4));
   rr_grant_arbiter #(.HOLD_MAX(1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req),
      .gnt(gnt_1), .gnt_idx(idx_1), .gnt_valid(vld_1), .expired(exp_1));

   typedef struct packed {
      logic [2:0][3:0] gnt;
      logic [2:0][1:0] idx;
      logic [2:0]      vld;
      logic [2:0]      exp;
   } exp_t;

   exp_t sb_q[$];

   // Reference model: owner (-1 = idle), last owner, cycles granted so far.
   int   m_owner [3];
   int   m_last  [3];
   int   m_held  [3];
   logic m_exp   [3];

   function automatic int hold_of(int k);
      case (k)
         0: return 8;
         1: return 4;
         default: return 1;
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int last);
      for (int s = 1; s <= 4; s++) begin
         int j;
         j = (last + s) % 4;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_owner[k] = -1;
         m_last[k]  = 3;
         m_held[k]  = 0;
         m_exp[k]   = 1'b0;
      end
   endtask

   task automatic model_step(input logic [3:0] r);
      for (int k = 0; k < 3; k++) begin
         int w;
         m_exp[k] = 1'b0;
         if (m_owner[k] < 0) begin
            w = pick(r, m_last[k]);
            if (w >= 0) begin
               m_owner[k] = w; m_last[k] = w; m_held[k] = 1;
            end
         end else if (!r[m_owner[k]]) begin
            w = pick(r, m_owner[k]);
            if (w >= 0) begin
               m_owner[k] = w; m_last[k] = w; m_held[k] = 1;
            end else begin
               m_owner[k] = -1; m_held[k] = 0;
            end
         end else if (m_held[k] == hold_of(k)) begin
            m_exp[k] = 1'b1;
            w = pick(r, m_owner[k]);
            m_owner[k] = w; m_last[k] = w; m_held[k] = 1;
         end else begin
            m_held[k]++;
         end
      end
   endtask

   function automatic exp_t snapshot();
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         e.gnt[k] = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
         e.idx[k] = (m_owner[k] >= 0) ? 2'(m_owner[k]) : 2'd0;
         e.vld[k] = (m_owner[k] >= 0);
         e.exp[k] = m_exp[k];
      end
      return e;
   endfunction

   task automatic compare_all();
      exp_t e;
      check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      check_eq("gnt_h8", {28'd0, gnt_8}, {28'd0, e.gnt[0]});
      check_eq("idx_h8", {30'd0, idx_8}, {30'd0, e.idx[0]});
      check_eq("vld_h8", {31'd0, vld_8}, {31'd0, e.vld[0]});
      check_eq("exp_h8", {31'd0, exp_8}, {31'd0, e.exp[0]});
      check_eq("gnt_h4", {28'd0, gnt_4}, {28'd0, e.gnt[1]});
      check_eq("idx_h4", {30'd0, idx_4}, {30'd0, e.idx[1]});
      check_eq("vld_h4", {31'd0, vld_4}, {31'd0, e.vld[1]});
      check_eq("exp_h4", {31'd0, exp_4}, {31'd0, e.exp[1]});
      check_eq("gnt_h1", {28'd0, gnt_1}, {28'd0, e.gnt[2]});
      check_eq("idx_h1", {30'd0, idx_1}, {30'd0, e.idx[2]});
      check_eq("vld_h1", {31'd0, vld_1}, {31'd0, e.vld[2]});
      check_eq("exp_h1", {31'd0, exp_1}, {31'd0, e.exp[2]});
   endtask

   // One clock: drive at the falling edge, predict, sample 1 time unit after the rising edge.
   task automatic step(input logic [3:0] r, input logic rst_v);
      @(negedge clk);
      rst = rst_v;
      req = r;
      if (rst_v) model_reset();
      else model_step(r);
      sb_q.push_back(snapshot());
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic repeat_step(input logic [3:0] r, input int n);
      for (int i = 0; i < n; i++) step(r, 1'b0);
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;

      // Reset with all requests pending.
      for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
      step(4'b1111, 1'b0);
      check_eq("rst_release_gnt", {28'd0, gnt_8}, 32'h1);
      check_eq("rst_release_idx", {30'd0, idx_8}, 32'h0);
      repeat_step(4'b0000, 2);

      // Single requester, voluntary release.
      repeat_step(4'b0100, 3);
      repeat_step(4'b0000, 3);

      // Saturation: rotation with expiries.
      repeat_step(4'b1111, 20);
      repeat_step(4'b0000, 2);

      // Lone hog: re-granted at every expiry.
      repeat_step(4'b0010, 12);
      repeat_step(4'b0000, 2);

      // Priority after release.
      repeat_step(4'b0100, 1);
      repeat_step(4'b1101, 1);
      repeat_step(4'b1001, 1);
      check_eq("prio_gnt", {28'd0, gnt_8}, 32'h8);
      check_eq("prio_idx", {30'd0, idx_8}, 32'h3);
      repeat_step(4'b0001, 1);
      check_eq("prio_next_gnt", {28'd0, gnt_8}, 32'h1);
      repeat_step(4'b0000, 2);

      // Asynchronous reset between edges while requester 2 owns.
      repeat_step(4'b0100, 2);
      #2 rst = 1'b1;
      #1;
      model_reset();
      sb_q.push_back(snapshot());
      compare_all();
      step(4'b0110, 1'b1);
      step(4'b0110, 1'b0);
      check_eq("async_rst_regrant", {28'd0, gnt_8}, 32'h2);
      repeat_step(4'b0000, 2);

      // Random traffic.
      for (int i = 0; i < 300; i++) step(4'($urandom_range(0, 15)), 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
